// File: rtl/ascii_dec_framer_if.sv
// Byte-in / BCD-out bundle between the UART receiver, the decimal framer and the 7-seg decoders.
interface ascii_dec_framer_if;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       num_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_byte, rx_done,
    input  bcd_tens, bcd_ones, num_valid, frame_err, busy
  );

  modport slave (
    input  rx_byte, rx_done,
    output bcd_tens, bcd_ones, num_valid, frame_err, busy
  );
endinterface

// File: rtl/ascii_dec_framer.sv
// Line-framed 1-2 digit ASCII decimal parser; commits the number as two BCD digits on CR/LF,
// discards malformed, overlong or stalled lines with a frame_err pulse.
module ascii_dec_framer #(
  parameter int unsigned TIMEOUT_CLKS = 8000
) (
  input logic             clk,
  input logic             rst,
  ascii_dec_framer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, D1, D2, DROP} state_t;

  state_t           state;
  logic [3:0]       d0;
  logic [3:0]       d1;
  logic [CNT_W-1:0] cnt;

  logic       is_digit_c;
  logic       is_term_c;
  logic       expire_c;
  logic [3:0] value_c;

  assign is_digit_c = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
  assign is_term_c  = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
  assign value_c    = 4'(bus.rx_byte - 8'h30);
  assign expire_c   = (cnt == CNT_W'(TIMEOUT_CLKS - 1));

  // A received byte always takes priority over timeout expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      d0            <= 4'd0;
      d1            <= 4'd0;
      cnt           <= '0;
      bus.bcd_tens  <= 4'd0;
      bus.bcd_ones  <= 4'd0;
      bus.num_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.num_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      if (bus.rx_done) begin
        cnt <= '0;
        case (state)
          IDLE: begin
            if (is_digit_c) begin
              d0       <= value_c;
              state    <= D1;
              bus.busy <= 1'b1;
            end else if (!is_term_c) begin
              bus.frame_err <= 1'b1;
              state         <= DROP;
              bus.busy      <= 1'b1;
            end
          end
          D1: begin
            if (is_digit_c) begin
              d1    <= value_c;
              state <= D2;
            end else if (is_term_c) begin
              bus.bcd_tens  <= 4'd0;
              bus.bcd_ones  <= d0;
              bus.num_valid <= 1'b1;
              state         <= IDLE;
              bus.busy      <= 1'b0;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= DROP;
            end
          end
          D2: begin
            if (is_term_c) begin
              bus.bcd_tens  <= d0;
              bus.bcd_ones  <= d1;
              bus.num_valid <= 1'b1;
              state         <= IDLE;
              bus.busy      <= 1'b0;
            end else begin
              // Third digit or garbage: line is rejected, swallow until terminator.
              bus.frame_err <= 1'b1;
              state         <= DROP;
            end
          end
          DROP: begin
            if (is_term_c) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (expire_c) begin
          cnt           <= '0;
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.frame_err <= (state != DROP);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ascii_dec_framer.sv
// Directed plus randomized bench for ascii_dec_framer against a line-level reference model.
module tb_ascii_dec_framer;

  localparam int unsigned T = 20;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  ascii_dec_framer_if bus ();

  ascii_dec_framer #(.TIMEOUT_CLKS(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a line is a list of held digits plus a "being dropped" flag.
  logic [3:0] m_digs[$];
  bit         m_drop;
  int         m_idle;
  logic [3:0] m_tens, m_ones;
  bit         m_nv, m_fe;

  function automatic void model_reset();
    m_digs.delete();
    m_drop = 0; m_idle = 0;
    m_tens = 4'd0; m_ones = 4'd0;
    m_nv = 0; m_fe = 0;
  endfunction

  function automatic bit line_active();
    return m_drop || (m_digs.size() > 0);
  endfunction

  function automatic void model_step(input bit done, input logic [7:0] b);
    m_nv = 0; m_fe = 0;
    if (done) begin
      m_idle = 0;
      if (b >= 8'h30 && b <= 8'h39) begin
        if (!m_drop) begin
          if (m_digs.size() < 2) m_digs.push_back(4'(b - 8'h30));
          else begin m_fe = 1; m_drop = 1; m_digs.delete(); end
        end
      end else if (b == 8'h0D || b == 8'h0A) begin
        if (!m_drop && m_digs.size() == 1) begin
          m_nv = 1; m_tens = 4'd0; m_ones = m_digs[0];
        end else if (!m_drop && m_digs.size() == 2) begin
          m_nv = 1; m_tens = m_digs[0]; m_ones = m_digs[1];
        end
        m_digs.delete(); m_drop = 0;
      end else if (!m_drop) begin
        m_fe = 1; m_drop = 1; m_digs.delete();
      end
    end else if (line_active()) begin
      m_idle++;
      if (m_idle == int'(T)) begin
        m_fe = !m_drop;
        m_drop = 0; m_digs.delete();
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("num_valid", 32'(bus.num_valid), 32'(m_nv));
    chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
    chk("bcd_tens", 32'(bus.bcd_tens), 32'(m_tens));
    chk("bcd_ones", 32'(bus.bcd_ones), 32'(m_ones));
    chk("busy", 32'(bus.busy), 32'(line_active()));
  endtask

  // One clock: drive inputs away from the edge, step model on the edge, sample 1ns later.
  task automatic tick(input bit done, input logic [7:0] b);
    bus.rx_done = done;
    bus.rx_byte = b;
    @(posedge clk);
    model_step(done, b);
    #1;
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'($urandom);
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  function automatic logic [7:0] pick_byte();
    int unsigned r;
    r = $urandom_range(0, 11);
    if (r < 7) return 8'h30 + 8'($urandom_range(0, 9));
    else if (r == 7) return 8'h0D;
    else if (r == 8) return 8'h0A;
    else if (r == 9) return 8'h78;
    else return 8'($urandom);
  endfunction

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
    rst = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // "42" CR
    send("4");
    chk("busy_after_4", 32'(bus.busy), 32'd1);
    send("2");
    send(8'h0D);
    chk("commit42_nv", 32'(bus.num_valid), 32'd1);
    chk("commit42_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h42);
    chk("commit42_busy", 32'(bus.busy), 32'd0);
    idle(1);

    // "7" CR LF: the LF is an empty line
    send("7"); send(8'h0D);
    chk("commit07_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h07);
    send(8'h0A);
    chk("lf_no_pulse", 32'(bus.num_valid), 32'd0);

    // overlong line keeps previous value
    send("4"); send("2"); send(8'h0D);
    send("1"); send("2"); send("3");
    chk("overflow_fe", 32'(bus.frame_err), 32'd1);
    send(8'h0A);
    chk("overflow_keep", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h42);
    chk("overflow_busy", 32'(bus.busy), 32'd0);
    send("0"); send("9"); send(8'h0D);
    chk("commit09_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h09);

    // non-digit inside line
    send("5"); send("x");
    chk("other_fe", 32'(bus.frame_err), 32'd1);
    send(8'h0D);
    chk("other_keep", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h09);
    send("8"); send(8'h0A);
    chk("commit08_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h08);

    // timeout after a single digit
    send("3");
    idle(int'(T) - 1);
    chk("pre_timeout_busy", 32'(bus.busy), 32'd1);
    idle(1);
    chk("timeout_fe", 32'(bus.frame_err), 32'd1);
    chk("timeout_busy", 32'(bus.busy), 32'd0);

    // byte arriving exactly at expiry wins
    send("3");
    idle(int'(T) - 1);
    send("4");
    chk("expiry_byte_no_fe", 32'(bus.frame_err), 32'd0);
    chk("expiry_byte_busy", 32'(bus.busy), 32'd1);
    send(8'h0D);
    chk("commit34_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h34);

    // timeout while dropping: silent return to idle
    send("x");
    idle(int'(T));
    chk("drop_timeout_busy", 32'(bus.busy), 32'd0);

    // reset mid-line
    send("6"); send("1");
    pulse_reset();
    send(8'h0D);
    chk("rst_no_commit", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h00);
    send("2"); send("5"); send(8'h0D);
    chk("commit25_val", {24'd0, bus.bcd_tens, bus.bcd_ones}, 32'h25);

    // randomized traffic, including long gaps that trip the timeout
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 12) send(pick_byte());
      else if (r < 19) idle(1);
      else idle(int'($urandom_range(T - 2, T + 3)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
